// File: rtl/pipeline_stage_chain_pkg.sv
// Shared constants and sizing helpers for the CPU inter-stage register chain.
package pipeline_stage_chain_pkg;

    // Default payload width follows the CPU datapath word.
    localparam int DEFAULT_WIDTH = 32;

    // Payload widths of the classic stage boundaries.
    localparam int IF_ID_WIDTH  = 32;
    localparam int ID_EX_WIDTH  = 98;
    localparam int EX_MEM_WIDTH = 72;
    localparam int MEM_WB_WIDTH = 71;

    typedef enum logic {
        SLICE_PASS = 1'b0,
        SLICE_SKID = 1'b1
    } slice_kind_e;

    function automatic slice_kind_e pl_slice_kind(input int skid);
        return (skid != 0) ? SLICE_SKID : SLICE_PASS;
    endfunction

    // Smallest r with 2**r >= value.
    function automatic int pl_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Beats the chain can hold: one per slice, two when each slice has a skid slot.
    function automatic int pl_cap(input int stages, input int skid);
        return stages * ((skid != 0) ? 2 : 1);
    endfunction

    function automatic int pl_occ_width(input int stages, input int skid);
        return pl_clog2(pl_cap(stages, skid) + 1);
    endfunction

endpackage

// File: rtl/pipeline_stage_chain_if.sv
// Valid/ready/data stream bundle; master drives valid+data, slave drives ready.
interface pipeline_stage_chain_if
    import pipeline_stage_chain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_skid_slice.sv
// One register slice of the chain. SKID selects between a main+skid pair with
// registered ready, or a single register whose ready passes through combinationally.
module pipeline_skid_slice
    import pipeline_stage_chain_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               SKID        = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready_dn
);

    localparam slice_kind_e KIND = pl_slice_kind(SKID);

    generate
        if (KIND == SLICE_SKID) begin : g_skid
            logic             r_main_valid;
            logic [WIDTH-1:0] r_main_data;
            logic             r_skid_valid;
            logic [WIDTH-1:0] r_skid_data;
            logic             w_accept;
            logic             w_drain;

            // Ready depends only on the skid slot, so no combinational path upstream.
            assign o_ready  = !r_skid_valid;
            assign w_accept = i_valid && !r_skid_valid;
            assign w_drain  = r_main_valid && i_ready_dn;

            // Main/skid movement: drain refills main from skid first, otherwise from input.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_main_data  <= RESET_VALUE;
                    r_skid_data  <= RESET_VALUE;
                end else if (i_flush) begin
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                end else if (w_drain) begin
                    if (r_skid_valid) begin
                        r_main_data  <= r_skid_data;
                        r_skid_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_main_data  <= i_data;
                    end else begin
                        r_main_valid <= 1'b0;
                    end
                end else if (w_accept) begin
                    if (r_main_valid) begin
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= i_data;
                    end else begin
                        r_main_valid <= 1'b1;
                        r_main_data  <= i_data;
                    end
                end
            end

            assign o_valid = r_main_valid;
            assign o_data  = r_main_data;
        end else begin : g_pass
            logic             r_valid;
            logic [WIDTH-1:0] r_data;
            logic             w_accept;
            logic             w_drain;

            // A full register can still take a beat when the next slice takes the current one.
            assign o_ready  = !r_valid || i_ready_dn;
            assign w_accept = i_valid && o_ready;
            assign w_drain  = r_valid && i_ready_dn;

            // Single register: load on accept, empty on drain without a replacement.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= RESET_VALUE;
                end else if (i_flush) begin
                    r_valid <= 1'b0;
                end else if (w_accept) begin
                    r_valid <= 1'b1;
                    r_data  <= i_data;
                end else if (w_drain) begin
                    r_valid <= 1'b0;
                end
            end

            assign o_valid = r_valid;
            assign o_data  = r_data;
        end
    endgenerate

endmodule

// File: rtl/pipeline_stage_chain.sv
// Parametrised inter-stage register chain with valid/ready backpressure,
// whole-chain flush and a registered occupancy count.
module pipeline_stage_chain
    import pipeline_stage_chain_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               STAGES      = 1,
    parameter int               SKID        = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              OCC_W       = pl_occ_width(STAGES, SKID)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    pipeline_stage_chain_if.slave  i_up,
    pipeline_stage_chain_if.master o_dn,
    output logic [OCC_W-1:0]       o_occupancy
);

    logic             w_in_ready;
    logic             w_out_valid;
    logic [WIDTH-1:0] w_out_data;
    logic             w_up_xfer;
    logic             w_dn_xfer;
    logic [OCC_W-1:0] r_occ;

    // Each stage keeps its own link wires so the ready chain is never one
    // self-referencing vector.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic             w_valid_in;
            logic [WIDTH-1:0] w_data_in;
            logic             w_ready_up;
            logic             w_valid_out;
            logic [WIDTH-1:0] w_data_out;
            logic             w_ready_dn;

            if (k == 0) begin : g_head
                assign w_valid_in = i_up.valid;
                assign w_data_in  = i_up.data;
            end else begin : g_link
                assign w_valid_in = g_stage[k-1].w_valid_out;
                assign w_data_in  = g_stage[k-1].w_data_out;
            end

            if (k == STAGES - 1) begin : g_tail
                assign w_ready_dn = o_dn.ready;
            end else begin : g_next
                assign w_ready_dn = g_stage[k+1].w_ready_up;
            end

            pipeline_skid_slice #(
                .WIDTH       (WIDTH),
                .SKID        (SKID),
                .RESET_VALUE (RESET_VALUE)
            ) u_slice (
                .clk        (clk),
                .rst        (rst),
                .i_flush    (i_flush),
                .i_valid    (w_valid_in),
                .i_data     (w_data_in),
                .o_ready    (w_ready_up),
                .o_valid    (w_valid_out),
                .o_data     (w_data_out),
                .i_ready_dn (w_ready_dn)
            );
        end
    endgenerate

    assign w_in_ready  = g_stage[0].w_ready_up;
    assign w_out_valid = g_stage[STAGES-1].w_valid_out;
    assign w_out_data  = g_stage[STAGES-1].w_data_out;

    assign i_up.ready = w_in_ready;
    assign o_dn.valid = w_out_valid;
    assign o_dn.data  = w_out_data;

    assign w_up_xfer = i_up.valid && w_in_ready;
    assign w_dn_xfer = w_out_valid && o_dn.ready;

    // Occupancy follows accepted minus delivered beats; reset and flush empty it.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_occ <= '0;
        end else if (w_up_xfer && !w_dn_xfer) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_up_xfer && w_dn_xfer) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    assign o_occupancy = r_occ;

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Directed tables, hand sequences and a random scoreboard run against three
// chain configurations.
module tb_pipeline_stage_chain;
    import pipeline_stage_chain_pkg::*;

    localparam int   W = 16;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       flush_a, flush_b, flush_c;
    logic [2:0] occ_a;
    logic [1:0] occ_b, occ_c;

    pipeline_stage_chain_if #(.WIDTH(W)) up_a ();
    pipeline_stage_chain_if #(.WIDTH(W)) dn_a ();
    pipeline_stage_chain_if #(.WIDTH(W)) up_b ();
    pipeline_stage_chain_if #(.WIDTH(W)) dn_b ();
    pipeline_stage_chain_if #(.WIDTH(W)) up_c ();
    pipeline_stage_chain_if #(.WIDTH(W)) dn_c ();

    // A: 3 skid slices, nonzero reset value. B: 1 skid slice. C: 2 pass-through slices.
    pipeline_stage_chain #(.WIDTH(W), .STAGES(3), .SKID(1), .RESET_VALUE(16'hDEAD)) u_dut_a (
        .clk(clk), .rst(rst), .i_flush(flush_a), .i_up(up_a), .o_dn(dn_a), .o_occupancy(occ_a));
    pipeline_stage_chain #(.WIDTH(W), .STAGES(1), .SKID(1), .RESET_VALUE(16'h0000)) u_dut_b (
        .clk(clk), .rst(rst), .i_flush(flush_b), .i_up(up_b), .o_dn(dn_b), .o_occupancy(occ_b));
    pipeline_stage_chain #(.WIDTH(W), .STAGES(2), .SKID(0), .RESET_VALUE(16'h0000)) u_dut_c (
        .clk(clk), .rst(rst), .i_flush(flush_c), .i_up(up_c), .o_dn(dn_c), .o_occupancy(occ_c));

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        fl;
        logic        e_irdy;
        logic        e_ov;
        logic [15:0] e_od;
        logic [2:0]  e_occ;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mv(logic iv, logic [15:0] id, logic ordy, logic fl,
                                logic e_irdy, logic e_ov, logic [15:0] e_od, logic [2:0] e_occ);
        vec_t r;
        r.iv = iv; r.id = id; r.ordy = ordy; r.fl = fl;
        r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_od = e_od; r.e_occ = e_occ;
        return r;
    endfunction

    // Apply one vector to B (dut=0) or C (dut=1) and compare after the edge.
    task automatic run_vec(input int dut, input int idx, input vec_t x);
        string tag;
        if (dut == 0) begin
            tag = $sformatf("B[%0d]", idx);
            up_b.valid = x.iv; up_b.data = x.id; dn_b.ready = x.ordy; flush_b = x.fl;
            step();
            chk({tag, " in_ready"},  32'(up_b.ready), 32'(x.e_irdy));
            chk({tag, " out_valid"}, 32'(dn_b.valid), 32'(x.e_ov));
            chk({tag, " out_data"},  32'(dn_b.data),  32'(x.e_od));
            chk({tag, " occupancy"}, 32'(occ_b),      32'(x.e_occ));
        end else begin
            tag = $sformatf("C[%0d]", idx);
            up_c.valid = x.iv; up_c.data = x.id; dn_c.ready = x.ordy; flush_c = x.fl;
            step();
            chk({tag, " in_ready"},  32'(up_c.ready), 32'(x.e_irdy));
            chk({tag, " out_valid"}, 32'(dn_c.valid), 32'(x.e_ov));
            chk({tag, " out_data"},  32'(dn_c.data),  32'(x.e_od));
            chk({tag, " occupancy"}, 32'(occ_c),      32'(x.e_occ));
        end
    endtask

    vec_t        vb[$];
    vec_t        vc[$];
    logic [15:0] qa[$];
    logic [15:0] qc[$];

    initial begin
        // B: backpressure, full boundary, accept+drain, flush (iv,id,ordy,fl | irdy,ov,od,occ)
        vb.push_back(mv(H, 16'h000A, L, L, H, H, 16'h000A, 3'd1));
        vb.push_back(mv(H, 16'h000B, L, L, L, H, 16'h000A, 3'd2));
        vb.push_back(mv(H, 16'h000C, L, L, L, H, 16'h000A, 3'd2));
        vb.push_back(mv(L, 16'h0000, H, L, H, H, 16'h000B, 3'd1));
        vb.push_back(mv(L, 16'h0000, H, L, H, L, 16'h000B, 3'd0));
        vb.push_back(mv(L, 16'h0000, L, L, H, L, 16'h000B, 3'd0));
        vb.push_back(mv(H, 16'h0001, L, L, H, H, 16'h0001, 3'd1));
        vb.push_back(mv(H, 16'h0002, L, L, L, H, 16'h0001, 3'd2));
        vb.push_back(mv(H, 16'h0003, H, L, H, H, 16'h0002, 3'd1));
        vb.push_back(mv(H, 16'h0003, H, L, H, H, 16'h0003, 3'd1));
        vb.push_back(mv(L, 16'h0000, H, L, H, L, 16'h0003, 3'd0));
        vb.push_back(mv(H, 16'h0004, L, L, H, H, 16'h0004, 3'd1));
        vb.push_back(mv(H, 16'h0005, L, H, H, L, 16'h0004, 3'd0));
        vb.push_back(mv(L, 16'h0000, L, L, H, L, 16'h0004, 3'd0));
        // C: pass-through ready follows out_ready when full, then flush
        vc.push_back(mv(H, 16'h0021, L, L, H, L, 16'h0000, 3'd1));
        vc.push_back(mv(H, 16'h0022, L, L, L, H, 16'h0021, 3'd2));
        vc.push_back(mv(H, 16'h0023, H, L, H, H, 16'h0022, 3'd2));
        vc.push_back(mv(H, 16'h0024, L, L, L, H, 16'h0022, 3'd2));
        vc.push_back(mv(H, 16'h0024, H, L, H, H, 16'h0023, 3'd2));
        vc.push_back(mv(H, 16'h0025, L, L, L, H, 16'h0023, 3'd2));
        vc.push_back(mv(L, 16'h0000, H, L, H, H, 16'h0024, 3'd1));
        vc.push_back(mv(L, 16'h0000, H, L, H, L, 16'h0024, 3'd0));
        vc.push_back(mv(H, 16'h0026, L, L, H, L, 16'h0024, 3'd1));
        vc.push_back(mv(H, 16'h0027, L, H, H, L, 16'h0024, 3'd0));
        vc.push_back(mv(L, 16'h0000, H, L, H, L, 16'h0024, 3'd0));

        rst = 1'b1;
        flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
        up_a.valid = 1'b0; up_a.data = '0; dn_a.ready = 1'b0;
        up_b.valid = 1'b0; up_b.data = '0; dn_b.ready = 1'b0;
        up_c.valid = 1'b0; up_c.data = '0; dn_c.ready = 1'b0;
        step();
        step();
        chk("rst A out_valid", 32'(dn_a.valid), 32'd0);
        chk("rst A out_data",  32'(dn_a.data),  32'h0000DEAD);
        chk("rst A occupancy", 32'(occ_a),      32'd0);
        chk("rst A in_ready",  32'(up_a.ready), 32'd1);
        chk("rst B out_valid", 32'(dn_b.valid), 32'd0);
        chk("rst B in_ready",  32'(up_b.ready), 32'd1);
        chk("rst C out_data",  32'(dn_c.data),  32'd0);
        chk("rst C in_ready",  32'(up_c.ready), 32'd1);
        rst = 1'b0;

        foreach (vb[i]) run_vec(0, i, vb[i]);
        up_b.valid = 1'b0; dn_b.ready = 1'b0; flush_b = 1'b0;
        foreach (vc[i]) run_vec(1, i, vc[i]);
        up_c.valid = 1'b0; dn_c.ready = 1'b0; flush_c = 1'b0;

        // A streaming: 0x11..0x18 back to back, out_ready held high
        dn_a.ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int e_occ;
            up_a.valid = (i < 8);
            up_a.data  = (i < 8) ? 16'(16'h11 + i) : 16'hxxxx;
            step();
            if (i < 2)      e_occ = i + 1;
            else if (i < 8) e_occ = 3;
            else if (i < 10) e_occ = 10 - i;
            else            e_occ = 0;
            chk($sformatf("stream[%0d] out_valid", i), 32'(dn_a.valid), 32'((i >= 2) && (i <= 9)));
            chk($sformatf("stream[%0d] occupancy", i), 32'(occ_a), 32'(e_occ));
            chk($sformatf("stream[%0d] in_ready", i),  32'(up_a.ready), 32'd1);
            if (i >= 2 && i <= 9) begin
                chk($sformatf("stream[%0d] out_data", i), 32'(dn_a.data), 32'(16'h11 + i - 2));
            end
        end

        // A flush: hold 0x5, 0x6, offer 0x7 with flush, then 0x8 comes through alone
        dn_a.ready = 1'b0;
        up_a.valid = 1'b1; up_a.data = 16'h0005; step();
        up_a.data = 16'h0006; step();
        chk("flush pre occupancy", 32'(occ_a), 32'd2);
        up_a.data = 16'h0007; flush_a = 1'b1; step();
        chk("flush out_valid", 32'(dn_a.valid), 32'd0);
        chk("flush occupancy", 32'(occ_a),      32'd0);
        chk("flush in_ready",  32'(up_a.ready), 32'd1);
        chk("flush data held", 32'(dn_a.data),  32'h18);
        flush_a = 1'b0; up_a.valid = 1'b0; up_a.data = 16'hxxxx; step();
        chk("post-flush occupancy", 32'(occ_a), 32'd0);
        up_a.valid = 1'b1; up_a.data = 16'h0008; dn_a.ready = 1'b1; step();
        up_a.valid = 1'b0; up_a.data = 16'hxxxx;
        chk("refill c0 out_valid", 32'(dn_a.valid), 32'd0);
        step();
        chk("refill c1 out_valid", 32'(dn_a.valid), 32'd0);
        step();
        chk("refill c2 out_valid", 32'(dn_a.valid), 32'd1);
        chk("refill c2 out_data",  32'(dn_a.data),  32'h8);
        step();
        chk("refill drained occupancy", 32'(occ_a), 32'd0);

        // A mid-stream reset when full; in_valid and flush during rst are ignored
        dn_a.ready = 1'b0; up_a.valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            up_a.data = 16'(16'h30 + i);
            step();
        end
        chk("full occupancy", 32'(occ_a),      32'd6);
        chk("full in_ready",  32'(up_a.ready), 32'd0);
        chk("full head data", 32'(dn_a.data),  32'h30);
        rst = 1'b1; flush_a = 1'b1; up_a.data = 16'h0099; step();
        chk("midrst out_valid", 32'(dn_a.valid), 32'd0);
        chk("midrst out_data",  32'(dn_a.data),  32'h0000DEAD);
        chk("midrst occupancy", 32'(occ_a),      32'd0);
        chk("midrst in_ready",  32'(up_a.ready), 32'd1);
        rst = 1'b0; flush_a = 1'b0; up_a.valid = 1'b0; step();
        chk("postrst occupancy", 32'(occ_a),      32'd0);
        chk("postrst out_valid", 32'(dn_a.valid), 32'd0);

        // Random traffic on A (skid) and C (pass-through) against scoreboards
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic iva, ivc;
            iva = ($urandom_range(0, 3) != 0);
            ivc = ($urandom_range(0, 3) != 0);
            up_a.valid = iva; up_a.data = iva ? 16'($urandom) : 16'hxxxx;
            dn_a.ready = ($urandom_range(0, 3) != 0);
            flush_a    = ($urandom_range(0, 31) == 0);
            up_c.valid = ivc; up_c.data = ivc ? 16'($urandom) : 16'hxxxx;
            dn_c.ready = ($urandom_range(0, 2) != 0);
            flush_c    = ($urandom_range(0, 31) == 0);
            #1;
            if (dn_a.valid && dn_a.ready) begin
                chk("rnd A beat expected", 32'(qa.size() > 0), 32'd1);
                if (qa.size() > 0) chk($sformatf("rnd A data @%0d", cyc), 32'(dn_a.data), 32'(qa.pop_front()));
            end
            if (up_a.valid && up_a.ready && !flush_a) qa.push_back(up_a.data);
            if (flush_a) qa.delete();
            if (dn_c.valid && dn_c.ready) begin
                chk("rnd C beat expected", 32'(qc.size() > 0), 32'd1);
                if (qc.size() > 0) chk($sformatf("rnd C data @%0d", cyc), 32'(dn_c.data), 32'(qc.pop_front()));
            end
            if (up_c.valid && up_c.ready && !flush_c) qc.push_back(up_c.data);
            if (flush_c) qc.delete();
            step();
            chk($sformatf("rnd A occupancy @%0d", cyc), 32'(occ_a), 32'(qa.size()));
            chk($sformatf("rnd C occupancy @%0d", cyc), 32'(occ_c), 32'(qc.size()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
